// File: rtl/apb_slave_resp_mux.sv
// APB completer-side response mux. Tracks each transfer from setup through
// access, routes the addressed slave's response to the bridge, and adds
// decode-error detection, a wait-state watchdog and a saturating error count.
module apb_slave_resp_mux #(
  parameter int DATA_WIDTH    = 32,
  parameter int SEL_WIDTH     = 4,
  parameter int TIMEOUT       = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             i_PCLK,
  input  logic                             i_PRESET,
  input  logic [SEL_WIDTH-1:0]             i_PSEL,
  input  logic                             i_PENABLE,
  input  logic                             i_PWRITE,
  input  logic [SEL_WIDTH-1:0]             i_PREADY,
  input  logic [SEL_WIDTH-1:0]             i_PSLVERR,
  input  logic [DATA_WIDTH*SEL_WIDTH-1:0]  i_PRDATA,
  output logic                             o_PREADY,
  output logic [DATA_WIDTH-1:0]            o_PRDATA,
  output logic                             o_PSLVERR,
  output logic                             o_TIMEOUT,
  output logic [ERR_CNT_WIDTH-1:0]         o_ERR_CNT
);

  localparam int IDX_W = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]         CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX   = '1;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx_q;
  logic                     dec_err_q;
  logic                     write_q;
  logic [CNT_W-1:0]         wait_cnt;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  logic [IDX_W-1:0]         setup_idx;
  logic                     setup_onehot;
  logic                     sel_ready;
  logic                     sel_err;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     access_active;
  logic                     timeout_hit;

  // Decode the setup-phase select: lowest set bit wins, flag anything not one-hot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    setup_idx = '0;
    for (int k = SEL_WIDTH - 1; k >= 0; k--) begin
      if (i_PSEL[k]) setup_idx = IDX_W'(k);
    end
    setup_onehot = (i_PSEL != '0) && ((i_PSEL & (i_PSEL - SEL_WIDTH'(1))) == '0);
  end

  // Pick out the latched slave's ready/error/data lanes.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = i_PREADY[k];
        sel_err   = i_PSLVERR[k];
        sel_data  = i_PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Response to the bridge: decode error first, then watchdog, then the slave itself.
  always_comb begin
    access_active = (state == S_ACCESS) && i_PENABLE && (i_PSEL != '0);
    timeout_hit   = (TIMEOUT != 0) && (wait_cnt == CNT_LIMIT) && !sel_ready;
    o_PREADY      = 1'b0;
    o_PSLVERR     = 1'b0;
    o_PRDATA      = '0;
    o_TIMEOUT     = 1'b0;
    if (access_active) begin
      if (dec_err_q) begin
        o_PREADY  = 1'b1;
        o_PSLVERR = 1'b1;
      end else if (timeout_hit) begin
        o_PREADY  = 1'b1;
        o_PSLVERR = 1'b1;
        o_TIMEOUT = 1'b1;
      end else begin
        o_PREADY  = sel_ready;
        o_PSLVERR = sel_err & sel_ready;
        o_PRDATA  = write_q ? '0 : sel_data;
      end
    end
  end

  // Transfer tracking FSM, wait-state counter and saturating error counter.
  always_ff @(posedge i_PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_PRESET) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      dec_err_q <= 1'b0;
      write_q   <= 1'b0;
      wait_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((i_PSEL != '0) && !i_PENABLE) begin
            state     <= S_ACCESS;
            idx_q     <= setup_idx;
            dec_err_q <= !setup_onehot;
            write_q   <= i_PWRITE;
            wait_cnt  <= '0;
          end
        end
        S_ACCESS: begin
          if (i_PSEL == '0) begin
            state <= S_IDLE;
          end else if (o_PREADY) begin
            state <= S_IDLE;
            if (o_PSLVERR && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
          end else if (i_PENABLE && (TIMEOUT != 0) && (wait_cnt != CNT_LIMIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ERR_CNT = err_cnt;

endmodule

// File: tb/tb_apb_slave_resp_mux.sv
// Randomised scoreboard bench for apb_slave_resp_mux (4 slaves, TIMEOUT=4).
module tb_apb_slave_resp_mux;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam int EW = 8;
  localparam int NEVER = 1000;

  logic              i_PCLK = 1'b0;
  logic              i_PRESET;
  logic [SW-1:0]     i_PSEL;
  logic              i_PENABLE;
  logic              i_PWRITE;
  logic [SW-1:0]     i_PREADY;
  logic [SW-1:0]     i_PSLVERR;
  logic [DW*SW-1:0]  i_PRDATA;
  logic              o_PREADY;
  logic [DW-1:0]     o_PRDATA;
  logic              o_PSLVERR;
  logic              o_TIMEOUT;
  logic [EW-1:0]     o_ERR_CNT;

  apb_slave_resp_mux #(
    .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TO), .ERR_CNT_WIDTH(EW)
  ) dut (
    .i_PCLK(i_PCLK), .i_PRESET(i_PRESET), .i_PSEL(i_PSEL), .i_PENABLE(i_PENABLE),
    .i_PWRITE(i_PWRITE), .i_PREADY(i_PREADY), .i_PSLVERR(i_PSLVERR), .i_PRDATA(i_PRDATA),
    .o_PREADY(o_PREADY), .o_PRDATA(o_PRDATA), .o_PSLVERR(o_PSLVERR),
    .o_TIMEOUT(o_TIMEOUT), .o_ERR_CNT(o_ERR_CNT)
  );

  always #5 i_PCLK = ~i_PCLK;

  typedef struct {
    int            cyc;   // 0-based access cycle on which the response appears
    logic [DW-1:0] data;
    logic          err;
    logic          tout;
    logic [EW-1:0] cnt;   // error count expected once the transfer has retired
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_PCLK);
    #1;
  endtask

  function automatic int lowest_bit(input logic [SW-1:0] sel);
    for (int k = 0; k < SW; k++) if (sel[k]) return k;
    return 0;
  endfunction

  function automatic bit is_onehot(input logic [SW-1:0] sel);
    return $countones(sel) == 1;
  endfunction

  // One APB transfer. lat = access cycles the addressed slave stays not-ready.
  // stop_at >= 0 ends the transfer early on that access cycle (PSEL drop, or reset).
  task automatic xfer(input logic [SW-1:0] psel, input logic wr, input int lat,
                      input logic serr, input logic [DW-1:0] data,
                      input int stop_at, input bit use_reset);
    int   idx;
    int   respc;
    exp_t e;
    idx = lowest_bit(psel);
    if (!is_onehot(psel)) begin
      respc = 0; e.data = '0; e.err = 1'b1; e.tout = 1'b0;
    end else if (TO > 0 && lat > TO) begin
      respc = TO; e.data = '0; e.err = 1'b1; e.tout = 1'b1;
    end else begin
      respc = lat; e.data = wr ? '0 : data; e.err = serr; e.tout = 1'b0;
    end
    e.cyc = respc;
    if (stop_at < 0) begin
      if (e.err && model_cnt < (1 << EW) - 1) model_cnt++;
      e.cnt = EW'(model_cnt);
      sb.push_back(e);
    end
    // setup phase
    i_PSEL = psel; i_PENABLE = 1'b0; i_PWRITE = wr;
    i_PREADY = '0; i_PSLVERR = SW'($urandom);
    for (int k = 0; k < SW; k++) i_PRDATA[k*DW +: DW] = $urandom;
    tick();
    i_PENABLE = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (c == stop_at) begin
        if (use_reset) begin
          i_PRESET = 1'b1;
          model_cnt = 0;
        end
        i_PSEL = '0; i_PENABLE = 1'b0;
        tick();
        i_PRESET = 1'b0;
        break;
      end
      i_PREADY  = SW'($urandom);
      i_PSLVERR = SW'($urandom);
      for (int k = 0; k < SW; k++) i_PRDATA[k*DW +: DW] = $urandom;
      if (is_onehot(psel)) begin
        i_PREADY[idx]  = (c >= lat);
        i_PSLVERR[idx] = serr;
        i_PRDATA[idx*DW +: DW] = data;
      end
      tick();
      if (c == respc) break;
    end
    i_PSEL = '0; i_PENABLE = 1'b0; i_PREADY = '0; i_PSLVERR = '0;
  endtask

  // Monitor: counts access cycles from the bench's own bus view and pops on every response.
  initial begin
    int   acc_cyc;
    bit   cnt_pending;
    logic [EW-1:0] cnt_exp;
    exp_t e;
    acc_cyc = 0;
    cnt_pending = 0;
    cnt_exp = '0;
    forever begin
      @(negedge i_PCLK);
      if (cnt_pending) begin
        check("err_cnt_after_xfer", o_ERR_CNT, cnt_exp);
        cnt_pending = 0;
      end
      if (i_PRESET) acc_cyc = 0;
      else if (i_PSEL != '0 && !i_PENABLE) acc_cyc = 0;
      else if (i_PSEL != '0 && i_PENABLE) acc_cyc++;
      if (o_TIMEOUT) check("timeout_with_ready", {o_TIMEOUT, o_PREADY}, 2'b11);
      if (o_PREADY) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", o_PREADY, 1'b0);
        end else begin
          e = sb.pop_front();
          check("resp_cycle",  acc_cyc - 1, e.cyc);
          check("resp_pslverr", o_PSLVERR, e.err);
          check("resp_prdata",  o_PRDATA,  e.data);
          check("resp_timeout", o_TIMEOUT, e.tout);
          cnt_exp = e.cnt;
          cnt_pending = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] psel;
    i_PRESET = 1'b1; i_PSEL = '0; i_PENABLE = 1'b0; i_PWRITE = 1'b0;
    i_PREADY = '0; i_PSLVERR = '0; i_PRDATA = '0;
    repeat (3) tick();
    i_PRESET = 1'b0;
    tick();
    check("reset_pready",  o_PREADY,  1'b0);
    check("reset_pslverr", o_PSLVERR, 1'b0);
    check("reset_prdata",  o_PRDATA,  '0);
    check("reset_err_cnt", o_ERR_CNT, '0);

    // read slave 2, ready on first access cycle
    xfer(4'b0100, 1'b0, 0, 1'b0, 32'hCAFE_0002, -1, 0);
    // write slave 1, two wait states
    xfer(4'b0010, 1'b1, 2, 1'b0, 32'h1234_5678, -1, 0);
    // read slave 3 stuck not-ready: watchdog fires on access cycle 4
    xfer(4'b1000, 1'b0, NEVER, 1'b0, 32'hDEAD_0003, -1, 0);
    // slave ready exactly on the watchdog cycle wins
    xfer(4'b1000, 1'b0, TO, 1'b0, 32'hBEEF_0003, -1, 0);
    // slave error response
    xfer(4'b0001, 1'b0, 1, 1'b1, 32'h0BAD_0000, -1, 0);
    tick();
    check("err_cnt_before_reset", o_ERR_CNT, EW'(model_cnt));

    // reset mid-wait: transfer abandoned, counter cleared
    xfer(4'b1000, 1'b0, NEVER, 1'b0, 32'h5555_0003, 2, 1);
    check("midreset_pready",  o_PREADY,  1'b0);
    check("midreset_timeout", o_TIMEOUT, 1'b0);
    check("midreset_err_cnt", o_ERR_CNT, '0);
    xfer(4'b0100, 1'b0, 1, 1'b0, 32'hA5A5_0002, -1, 0);

    // PSEL dropped mid-access: no response, count unchanged
    xfer(4'b0001, 1'b0, 3, 1'b1, 32'h7777_0000, 1, 0);
    tick();
    check("abort_err_cnt", o_ERR_CNT, EW'(model_cnt));
    xfer(4'b0010, 1'b0, 0, 1'b0, 32'h1111_0001, -1, 0);

    // randomised mix, occasionally back-to-back
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) psel = SW'($urandom_range(1, (1 << SW) - 1));
      else psel = SW'(1) << $urandom_range(0, SW - 1);
      xfer(psel, 1'($urandom), $urandom_range(0, 6), ($urandom_range(0, 3) == 0), $urandom, -1, 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // decode-error flood saturates the error counter
    for (int n = 0; n < 300; n++) xfer(4'b0110, 1'b0, 0, 1'b0, 32'h0, -1, 0);
    tick();
    check("err_cnt_saturated", o_ERR_CNT, 8'hFF);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
